// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the write-back stage: datapath defaults,
// the hardwired zero register index and the MEM/WB wb control field layout.
package wb_regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam int REG_ZERO = 0;

    // MEM/WB wb field: {reg_write, mem_to_reg}
    localparam int WB_CTRL_W         = 2;
    localparam int WB_REG_WRITE_BIT  = 1;
    localparam int WB_MEM_TO_REG_BIT = 0;

endpackage

// File: rtl/wb_regfile_reg_array.sv
// Plain register storage: synchronous clear, one write port, two
// asynchronous read ports. Zero-register and bypass handling live above.
module reg_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it to the register
// file, serves two decode read ports with write-through bypass, counts retires.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [31:0]       retire_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [WB_CTRL_W-1:0] wb_ctrl;
    logic [DATA_W-1:0]    stored_rs;
    logic [DATA_W-1:0]    stored_rt;

    assign wb_ctrl[WB_REG_WRITE_BIT]  = reg_write;
    assign wb_ctrl[WB_MEM_TO_REG_BIT] = mem_to_reg;

    // The mux is independent of reg_write so EX forwarding sees it regardless.
    assign wb_data = wb_ctrl[WB_MEM_TO_REG_BIT] ? mem_data : alu_data;
    assign wb_we   = wb_ctrl[WB_REG_WRITE_BIT] && (wb_rd != ZERO_IDX);

    reg_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_reg_array (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (stored_rs),
        .rdata_b (stored_rt)
    );

    // Zero index wins over bypass; bypass stays live during rst.
    always_comb begin
        rs_data = stored_rs;
        if (rs_addr == ZERO_IDX) begin
            rs_data = '0;
        end else if (wb_we && (rs_addr == wb_rd)) begin
            rs_data = wb_data;
        end
    end

    always_comb begin
        rt_data = stored_rt;
        if (rt_addr == ZERO_IDX) begin
            rt_data = '0;
        end else if (wb_we && (rt_addr == wb_rd)) begin
            rt_data = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (wb_we) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

endmodule
